cpu_debug_controller: RTL and testbench
=======================================

Name: cpu_debug_controller

Overview:
- Run-control and state-inspection controller for the cpu32e2 debug lines bundle.
- Accepts host commands (halt, run, single-step, read state, set/clear breakpoint) over a valid/ready command channel and returns one response per command.
- Gates CPU progress via a run-enable at machine-cycle boundaries.
- Sits between the debug transport (UART/JTAG bridge) and the CPU core.

Parameters:
- NUM_BP, 2, number of PC breakpoint comparators (1..8).
- RESET_HALTED, 0, if 1 the controller leaves reset in HALTED with cause HOST; if 0, in RUNNING.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- debugState  in  debugLines (1124 bits)  CPU state bundle: fetchCycle, machineCycleDone, regfileState, nextPCState, flags, systemCall, isrBaseAddress, interruptEnable, exceptionMask, cause.
- cpuRun  out  1  registered; CPU may begin a new machine cycle from fetch only while high.
- cmdValid  in  1  command valid.
- cmdReady  out  1  command accepted when cmdValid&&cmdReady.
- cmdOp  in  3  0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 READ, 5 SET_BP, 6 CLR_BP, 7 illegal.
- cmdAddr  in  6  READ address or breakpoint index.
- cmdData  in  32  breakpoint address for SET_BP.
- rspValid  out  1  response valid, held until accepted.
- rspReady  in  1  response consumed when rspValid&&rspReady.
- rspData  out  32  READ data, or status word for all other ops.
- halted  out  1  high in HALTED.
- haltCause  out  2  0 NONE, 1 HOST, 2 BREAKPOINT, 3 STEP.

Behaviour:
- Reset (async, reset_n low), RESET_HALTED=0: state RUNNING, cpuRun=1, halted=0, haltCause=NONE.
- Reset, RESET_HALTED=1: state HALTED, cpuRun=0, halted=1, haltCause=HOST.
- Reset, both cases: rspValid=0, rspData=0, all breakpoints disabled, addresses 0.
- "done" means debugState.machineCycleDone sampled high on a rising edge.
- States and transitions:
  - RUNNING: on done with nextPCState equal to any enabled breakpoint → HALTED, cause BREAKPOINT, cpuRun=0 next cycle. Else a HALT accept → HALT_PENDING.
  - HALT_PENDING: cpuRun stays 1. Next done → HALTED, cause HOST. A breakpoint match on that done gives cause BREAKPOINT instead.
  - HALTED: cpuRun=0. RUN accept → RUNNING, cause NONE, cpuRun=1 next cycle. STEP accept → STEPPING, cpuRun=1.
  - STEPPING: next done → HALTED, cause STEP, cpuRun=0. Breakpoints are not evaluated while stepping, so stepping off a breakpoint works.
- A done and a HALT accept in the same RUNNING cycle: a breakpoint match wins. Otherwise go to HALT_PENDING and halt on the following done.
- cmdReady = !rspValid | rspReady; one command in flight, back-to-back allowed.
- Every accepted command loads rspValid=1 on the next edge with rspData. rspValid clears on rspReady when no new accept occurs.
- Status word: bit0 halted, bits2:1 haltCause, bits5:3 state, bit31 error, others 0.
- Errors (bit31 set, no state change):
  - opcode 7;
  - STEP when not HALTED;
  - SET_BP/CLR_BP with cmdAddr >= NUM_BP.
- No-ops with an ordinary status response:
  - HALT in HALTED, HALT_PENDING or STEPPING;
  - RUN in RUNNING, HALT_PENDING or STEPPING;
  - NOP.
- READ is legal in any state and snapshots debugState on the accept cycle. Address map:
  - 0–31: regfile[n];
  - 32: nextPC;
  - 33: {28'0,flags};
  - 34: {24'0,systemCall};
  - 35: isrBaseAddress;
  - 36: {31'0,interruptEnable};
  - 37: {16'0,exceptionMask};
  - 38: {27'0,cause};
  - 39: status word;
  - 40–47: breakpoint address n-40;
  - 48: breakpoint enable mask (zero-extended);
  - 40–48 entries beyond NUM_BP read 0;
  - 49–63 read 0, no error.
- SET_BP writes the address and sets enable. CLR_BP clears enable and leaves the address. Both take effect for comparisons from the cycle after accept.
- Breakpoint compare is full 32-bit equality on nextPCState.

Decomposition:
- Add to debugPkg:
  - debugOp enum (3 bits);
  - haltCause enum (2 bits);
  - debugState enum (3 bits);
  - status word packed struct;
  - READ address constants (DBG_ADDR_NEXTPC=32 … DBG_ADDR_BPMASK=48).
- Sub-module: debug_breakpoint_unit. It holds the NUM_BP address/enable registers, handles set/clear, and outputs a one-bit match on nextPCState.

Test Plan:
- RESET_HALTED=0, reset released → cpuRun=1, halted=0. HALT, then done pulse → cpuRun=0 next cycle, halted=1, haltCause=1, one status response with bit0=1.
- While halted: READ addr 5 with regfile[5]=0x1234ABCD → rspData=0x1234ABCD. READ 32 → nextPC. READ 55 → 0 with bit31=0. Hold rspReady=0 for 4 cycles → rspValid and rspData stable, cmdReady=0.
- SET_BP idx1 = 0x00000100, RUN, done with nextPC=0x100 → HALTED, cause 2, cpuRun low one cycle after done. READ 48 → 0x2.
- From breakpoint halt, STEP → cpuRun=1 until one done with nextPC=0x100 still matching → HALTED cause 3, not 2.
- Errors: STEP while RUNNING, SET_BP idx=5 with NUM_BP=2, and op 7 → each response has bit31=1 and state unchanged. HALT accepted with a bp-matching done in the same cycle → cause 2.
- Assert reset_n low in STEPPING with rspValid=1 → rspValid=0, state RUNNING, breakpoints disabled, cpuRun=1 immediately.

Source files
------------

// File: rtl/cpu_debug_controller_pkg.sv
// Shared types and constants for the cpu32e2 debug run-control controller:
// command opcodes, halt causes, controller states, status word and CPU state bundle.
package cpu_debug_controller_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_HALT    = 3'd1,
        OP_RUN     = 3'd2,
        OP_STEP    = 3'd3,
        OP_READ    = 3'd4,
        OP_SET_BP  = 3'd5,
        OP_CLR_BP  = 3'd6,
        OP_ILLEGAL = 3'd7
    } debug_op_e;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'd0,
        CAUSE_HOST       = 2'd1,
        CAUSE_BREAKPOINT = 2'd2,
        CAUSE_STEP       = 2'd3
    } halt_cause_e;

    typedef enum logic [2:0] {
        ST_RUNNING      = 3'd0,
        ST_HALT_PENDING = 3'd1,
        ST_HALTED       = 3'd2,
        ST_STEPPING     = 3'd3
    } debug_state_e;

    typedef struct packed {
        logic         error;
        logic [24:0]  rsvd;
        debug_state_e state;
        halt_cause_e  cause;
        logic         halted;
    } status_word_t;

    // 1124-bit CPU state bundle, field order as the core drives it.
    typedef struct packed {
        logic              fetchCycle;
        logic              machineCycleDone;
        logic [31:0][31:0] regfileState;
        logic [31:0]       nextPCState;
        logic [3:0]        flags;
        logic [7:0]        systemCall;
        logic [31:0]       isrBaseAddress;
        logic              interruptEnable;
        logic [15:0]       exceptionMask;
        logic [4:0]        cause;
    } debug_lines_t;

    localparam logic [5:0] DBG_ADDR_NEXTPC  = 6'd32;
    localparam logic [5:0] DBG_ADDR_FLAGS   = 6'd33;
    localparam logic [5:0] DBG_ADDR_SYSCALL = 6'd34;
    localparam logic [5:0] DBG_ADDR_ISRBASE = 6'd35;
    localparam logic [5:0] DBG_ADDR_IE      = 6'd36;
    localparam logic [5:0] DBG_ADDR_EXCMASK = 6'd37;
    localparam logic [5:0] DBG_ADDR_CAUSE   = 6'd38;
    localparam logic [5:0] DBG_ADDR_STATUS  = 6'd39;
    localparam logic [5:0] DBG_ADDR_BP0     = 6'd40;
    localparam logic [5:0] DBG_ADDR_BPMASK  = 6'd48;

    function automatic status_word_t make_status(debug_state_e st, halt_cause_e c, logic err);
        status_word_t s;
        s.error  = err;
        s.rsvd   = '0;
        s.state  = st;
        s.cause  = c;
        s.halted = (st == ST_HALTED);
        return s;
    endfunction

endpackage

// File: rtl/cpu_debug_controller_if.sv
// Host-side command/response channel of the debug controller (valid/ready both ways).
interface cpu_debug_controller_if;
    logic        cmdValid;
    logic        cmdReady;
    logic [2:0]  cmdOp;
    logic [5:0]  cmdAddr;
    logic [31:0] cmdData;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspData;

    modport master (
        output cmdValid, cmdOp, cmdAddr, cmdData, rspReady,
        input  cmdReady, rspValid, rspData
    );

    modport slave (
        input  cmdValid, cmdOp, cmdAddr, cmdData, rspReady,
        output cmdReady, rspValid, rspData
    );
endinterface

// File: rtl/debug_breakpoint_unit.sv
// NUM_BP PC breakpoint comparators: address/enable registers with set/clear
// and a single match flag against the CPU's next PC.
module debug_breakpoint_unit #(
    parameter int NUM_BP = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   set_i,
    input  logic                   clr_i,
    input  logic [5:0]             idx_i,
    input  logic [31:0]            addr_i,
    input  logic [31:0]            pc_i,
    output logic                   match_o,
    output logic [NUM_BP-1:0][31:0] bp_addr_o,
    output logic [NUM_BP-1:0]      bp_en_o
);

    logic [NUM_BP-1:0][31:0] addr_q, addr_d;
    logic [NUM_BP-1:0]       en_q, en_d;
    logic [NUM_BP-1:0]       hit;

    always_comb begin
        addr_d = addr_q;
        en_d   = en_q;
        for (int i = 0; i < NUM_BP; i++) begin
            if (idx_i == 6'(i)) begin
                if (set_i) begin
                    addr_d[i] = addr_i;
                    en_d[i]   = 1'b1;
                end else if (clr_i) begin
                    en_d[i]   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            en_q   <= '0;
        end else begin
            addr_q <= addr_d;
            en_q   <= en_d;
        end
    end

    for (genvar g = 0; g < NUM_BP; g++) begin : g_cmp
        assign hit[g] = en_q[g] && (addr_q[g] == pc_i);
    end

    assign match_o   = |hit;
    assign bp_addr_o = addr_q;
    assign bp_en_o   = en_q;

endmodule

// File: rtl/cpu_debug_controller.sv
// Debug run-control for cpu32e2: halt/run/step gating at machine-cycle boundaries,
// PC breakpoints, and state readback, one response per host command.
module cpu_debug_controller
    import cpu_debug_controller_pkg::*;
#(
    parameter int NUM_BP       = 2,
    parameter bit RESET_HALTED = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  debug_lines_t                 debugState,
    output logic                         cpuRun,
    output logic                         halted,
    output logic [1:0]                   haltCause,
    cpu_debug_controller_if.slave        dbg
);

    localparam debug_state_e RST_STATE = RESET_HALTED ? ST_HALTED : ST_RUNNING;
    localparam halt_cause_e  RST_CAUSE = RESET_HALTED ? CAUSE_HOST : CAUSE_NONE;
    localparam logic [6:0]   NUM_BP_W  = 7'(NUM_BP);

    debug_state_e state_q, state_d;
    halt_cause_e  cause_q, cause_d;
    logic         cpu_run_q, cpu_run_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [31:0]  rsp_data_q, rsp_data_d;

    debug_op_e    op;
    logic         cmd_ready, accept, done, idx_ok, err;
    logic         bp_set, bp_clr, bp_match;
    status_word_t status;
    logic [31:0]  read_data;
    logic [NUM_BP-1:0][31:0] bp_addr;
    logic [NUM_BP-1:0]       bp_en;
    logic         unused_fetch;

    assign unused_fetch = debugState.fetchCycle;
    assign op        = debug_op_e'(dbg.cmdOp);
    assign cmd_ready = !rsp_valid_q || dbg.rspReady;
    assign accept    = dbg.cmdValid && cmd_ready;
    assign done      = debugState.machineCycleDone;
    assign idx_ok    = {1'b0, dbg.cmdAddr} < NUM_BP_W;

    debug_breakpoint_unit #(.NUM_BP(NUM_BP)) u_bp (
        .clk       (clk),
        .reset_n   (reset_n),
        .set_i     (bp_set),
        .clr_i     (bp_clr),
        .idx_i     (dbg.cmdAddr),
        .addr_i    (dbg.cmdData),
        .pc_i      (debugState.nextPCState),
        .match_o   (bp_match),
        .bp_addr_o (bp_addr),
        .bp_en_o   (bp_en)
    );

    // Command decode: rejected commands only raise the error bit.
    always_comb begin
        err    = 1'b0;
        bp_set = 1'b0;
        bp_clr = 1'b0;
        if (accept) begin
            case (op)
                OP_STEP:    err = (state_q != ST_HALTED);
                OP_SET_BP:  begin bp_set = idx_ok; err = !idx_ok; end
                OP_CLR_BP:  begin bp_clr = idx_ok; err = !idx_ok; end
                OP_ILLEGAL: err = 1'b1;
                default:    ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_RUNNING: begin
                // A breakpoint hit on this boundary beats a same-cycle HALT.
                if (done && bp_match) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_BREAKPOINT;
                end else if (accept && op == OP_HALT) begin
                    state_d = ST_HALT_PENDING;
                end
            end
            ST_HALT_PENDING: begin
                if (done) begin
                    state_d = ST_HALTED;
                    if (bp_match) cause_d = CAUSE_BREAKPOINT;
                    else          cause_d = CAUSE_HOST;
                end
            end
            ST_HALTED: begin
                if (accept && op == OP_RUN) begin
                    state_d = ST_RUNNING;
                    cause_d = CAUSE_NONE;
                end else if (accept && op == OP_STEP) begin
                    state_d = ST_STEPPING;
                end
            end
            ST_STEPPING: begin
                // Breakpoints ignored here so a step can leave a breakpoint PC.
                if (done) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_STEP;
                end
            end
            default: state_d = ST_HALTED;
        endcase
    end

    assign status    = make_status(state_d, cause_d, err);
    assign cpu_run_d = (state_d != ST_HALTED);

    always_comb begin
        read_data = '0;
        if (!dbg.cmdAddr[5]) begin
            read_data = debugState.regfileState[dbg.cmdAddr[4:0]];
        end else begin
            case (dbg.cmdAddr)
                DBG_ADDR_NEXTPC:  read_data = debugState.nextPCState;
                DBG_ADDR_FLAGS:   read_data = {28'b0, debugState.flags};
                DBG_ADDR_SYSCALL: read_data = {24'b0, debugState.systemCall};
                DBG_ADDR_ISRBASE: read_data = debugState.isrBaseAddress;
                DBG_ADDR_IE:      read_data = {31'b0, debugState.interruptEnable};
                DBG_ADDR_EXCMASK: read_data = {16'b0, debugState.exceptionMask};
                DBG_ADDR_CAUSE:   read_data = {27'b0, debugState.cause};
                DBG_ADDR_STATUS:  read_data = status;
                DBG_ADDR_BPMASK:  read_data = 32'(bp_en);
                default: begin
                    if (dbg.cmdAddr >= DBG_ADDR_BP0 && dbg.cmdAddr < DBG_ADDR_BPMASK) begin
                        for (int i = 0; i < NUM_BP; i++) begin
                            if (dbg.cmdAddr[2:0] == 3'(i)) read_data = bp_addr[i];
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = (op == OP_READ) ? read_data : status;
        end else if (dbg.rspReady) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RST_STATE;
            cause_q     <= RST_CAUSE;
            cpu_run_q   <= !RESET_HALTED;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            cpu_run_q   <= cpu_run_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cpuRun       = cpu_run_q;
    assign halted       = (state_q == ST_HALTED);
    assign haltCause    = cause_q;
    assign dbg.cmdReady = cmd_ready;
    assign dbg.rspValid = rsp_valid_q;
    assign dbg.rspData  = rsp_data_q;

endmodule

// File: tb/tb_cpu_debug_controller.sv
// Directed bench for cpu_debug_controller (NUM_BP=2, RESET_HALTED=0).
module tb_cpu_debug_controller;
    import cpu_debug_controller_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    debug_lines_t ds;
    logic         cpuRun, halted;
    logic [1:0]   haltCause;
    int           tests = 0;
    int           failed = 0;
    logic [31:0]  r;

    cpu_debug_controller_if dbg();

    cpu_debug_controller #(.NUM_BP(2), .RESET_HALTED(1'b0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .debugState (ds),
        .cpuRun     (cpuRun),
        .halted     (halted),
        .haltCause  (haltCause),
        .dbg        (dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [5:0] addr, input logic [31:0] data,
                        output logic [31:0] rsp);
        int n = 0;
        while (dbg.cmdReady !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready", {31'b0, dbg.cmdReady}, 32'd1);
        dbg.cmdValid = 1'b1;
        dbg.cmdOp    = op;
        dbg.cmdAddr  = addr;
        dbg.cmdData  = data;
        tick();
        dbg.cmdValid = 1'b0;
        chk("rsp_valid", {31'b0, dbg.rspValid}, 32'd1);
        rsp = dbg.rspData;
    endtask

    task automatic cmd(input string tag, input logic [2:0] op, input logic [5:0] addr,
                       input logic [31:0] data, input logic [31:0] exp);
        logic [31:0] rr;
        send(op, addr, data, rr);
        chk(tag, rr, exp);
    endtask

    task automatic done_pulse(input logic [31:0] pc);
        ds.nextPCState      = pc;
        ds.machineCycleDone = 1'b1;
        tick();
        ds.machineCycleDone = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ds = '0;
        for (int i = 0; i < 32; i++) ds.regfileState[i] = 32'h1000_0000 + 32'(i);
        ds.regfileState[5] = 32'h1234_ABCD;
        ds.flags           = 4'hA;
        ds.isrBaseAddress  = 32'hCAFE_0000;
        dbg.cmdValid = 1'b0;
        dbg.cmdOp    = 3'd0;
        dbg.cmdAddr  = 6'd0;
        dbg.cmdData  = 32'd0;
        dbg.rspReady = 1'b1;
        reset_n      = 1'b0;
        #12;
        chk("rst_cpuRun", {31'b0, cpuRun}, 32'd1);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_cause", {30'b0, haltCause}, 32'd0);
        chk("rst_rspValid", {31'b0, dbg.rspValid}, 32'd0);
        chk("rst_rspData", dbg.rspData, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Host halt: pending until the next machine-cycle boundary.
        cmd("halt_rsp", 3'd1, 6'd0, 32'd0, 32'h08);
        chk("pend_cpuRun", {31'b0, cpuRun}, 32'd1);
        done_pulse(32'h40);
        chk("halt_cpuRun", {31'b0, cpuRun}, 32'd0);
        chk("halt_halted", {31'b0, halted}, 32'd1);
        chk("halt_cause", {30'b0, haltCause}, 32'd1);
        cmd("nop_status", 3'd0, 6'd0, 32'd0, 32'h13);

        cmd("read_r5", 3'd4, 6'd5, 32'd0, 32'h1234_ABCD);
        cmd("read_r0", 3'd4, 6'd0, 32'd0, 32'h1000_0000);
        cmd("read_pc", 3'd4, 6'd32, 32'd0, 32'h40);
        cmd("read_isr", 3'd4, 6'd35, 32'd0, 32'hCAFE_0000);
        cmd("read_status", 3'd4, 6'd39, 32'd0, 32'h13);
        cmd("read_55", 3'd4, 6'd55, 32'd0, 32'h0);

        // Response held under back-pressure.
        tick();
        dbg.rspReady = 1'b0;
        send(3'd4, 6'd33, 32'd0, r);
        chk("read_flags", r, 32'hA);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_valid", {31'b0, dbg.rspValid}, 32'd1);
            chk("hold_data", dbg.rspData, 32'hA);
            chk("hold_cmdReady", {31'b0, dbg.cmdReady}, 32'd0);
        end
        dbg.rspReady = 1'b1;
        tick();
        chk("drain_valid", {31'b0, dbg.rspValid}, 32'd0);

        // Breakpoint halt.
        cmd("setbp1", 3'd5, 6'd1, 32'h100, 32'h13);
        cmd("run", 3'd2, 6'd0, 32'd0, 32'h00);
        chk("run_cpuRun", {31'b0, cpuRun}, 32'd1);
        done_pulse(32'h80);
        chk("nomatch_halted", {31'b0, halted}, 32'd0);
        chk("pre_bp_cpuRun", {31'b0, cpuRun}, 32'd1);
        done_pulse(32'h100);
        chk("bp_cpuRun", {31'b0, cpuRun}, 32'd0);
        chk("bp_halted", {31'b0, halted}, 32'd1);
        chk("bp_cause", {30'b0, haltCause}, 32'd2);
        cmd("read_mask", 3'd4, 6'd48, 32'd0, 32'h2);
        cmd("read_bp1", 3'd4, 6'd41, 32'd0, 32'h100);
        cmd("read_bp0", 3'd4, 6'd40, 32'd0, 32'h0);
        cmd("read_bp2_absent", 3'd4, 6'd42, 32'd0, 32'h0);

        // Step off the breakpoint.
        cmd("step_rsp", 3'd3, 6'd0, 32'd0, 32'h1C);
        chk("step_cpuRun", {31'b0, cpuRun}, 32'd1);
        tick();
        chk("step_wait_cpuRun", {31'b0, cpuRun}, 32'd1);
        chk("step_wait_halted", {31'b0, halted}, 32'd0);
        done_pulse(32'h100);
        chk("step_cause", {30'b0, haltCause}, 32'd3);
        chk("step_halted", {31'b0, halted}, 32'd1);
        chk("step_cpuRun_off", {31'b0, cpuRun}, 32'd0);

        // Error responses leave state alone.
        cmd("run2", 3'd2, 6'd0, 32'd0, 32'h00);
        cmd("err_step", 3'd3, 6'd0, 32'd0, 32'h8000_0000);
        cmd("err_setbp5", 3'd5, 6'd5, 32'h200, 32'h8000_0000);
        cmd("err_op7", 3'd7, 6'd0, 32'd0, 32'h8000_0000);
        cmd("run_noop", 3'd2, 6'd0, 32'd0, 32'h00);
        chk("err_halted", {31'b0, halted}, 32'd0);
        chk("err_cpuRun", {31'b0, cpuRun}, 32'd1);
        cmd("clrbp1", 3'd6, 6'd1, 32'd0, 32'h00);
        cmd("clr_mask", 3'd4, 6'd48, 32'd0, 32'h0);
        cmd("clr_addr_kept", 3'd4, 6'd41, 32'd0, 32'h100);
        done_pulse(32'h100);
        chk("clr_nohalt", {31'b0, halted}, 32'd0);

        // HALT accepted on a breakpoint-matching boundary.
        cmd("setbp1_again", 3'd5, 6'd1, 32'h100, 32'h00);
        ds.nextPCState      = 32'h100;
        ds.machineCycleDone = 1'b1;
        send(3'd1, 6'd0, 32'd0, r);
        ds.machineCycleDone = 1'b0;
        chk("halt_bp_rsp", r, 32'h15);
        chk("halt_bp_cause", {30'b0, haltCause}, 32'd2);
        chk("halt_bp_cpuRun", {31'b0, cpuRun}, 32'd0);

        // Reset while stepping with a response outstanding.
        tick();
        dbg.rspReady = 1'b0;
        cmd("step2", 3'd3, 6'd0, 32'd0, 32'h1C);
        reset_n = 1'b0;
        #1;
        chk("rst2_rspValid", {31'b0, dbg.rspValid}, 32'd0);
        chk("rst2_cpuRun", {31'b0, cpuRun}, 32'd1);
        chk("rst2_halted", {31'b0, halted}, 32'd0);
        chk("rst2_cause", {30'b0, haltCause}, 32'd0);
        reset_n      = 1'b1;
        dbg.rspReady = 1'b1;
        tick();
        cmd("rst2_mask", 3'd4, 6'd48, 32'd0, 32'h0);
        cmd("rst2_bp1", 3'd4, 6'd41, 32'd0, 32'h0);
        cmd("rst2_status", 3'd4, 6'd39, 32'd0, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
